// File: rtl/vta_mem_pkg.sv
// Shared opcode constants, FSM state type and index-width helper for the memory arbiter.
package vta_mem_pkg;

    localparam logic MEM_OP_RD = 1'b0;
    localparam logic MEM_OP_WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } mem_state_e;

    // Width of a client index; never zero so a single-bit select always exists.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vta_mem_arbiter_rr.sv
// Round-robin arbiter: first requester at or after the pointer wins; pointer moves past
// the winner on accept.
module rr_arbiter
    import vta_mem_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N-1:0]             req,
    input  logic                     en,
    input  logic                     accept,
    output logic [N-1:0]             grant,
    output logic [idx_bits(N)-1:0]   grant_idx,
    output logic                     grant_valid
);

    localparam int IW = idx_bits(N);

    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic          found;

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < N; off++) begin
            int j;
            j = int'(ptr_reg) + off;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    assign grant_valid = found && en;

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign grant[gi] = grant_valid && (grant_idx == IW'(gi));
    end

    assign ptr_next = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (accept) begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/vta_mem_arbiter.sv
// Shares one VTAMemDPI-style memory port among NUM_CLIENTS burst clients, one burst
// in flight at a time, with data routed only to or from the granted client.
module vta_mem_arbiter
    import vta_mem_pkg::*;
#(
    parameter int NUM_CLIENTS   = 2,
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [NUM_CLIENTS-1:0]                     cli_req_valid,
    output logic [NUM_CLIENTS-1:0]                     cli_req_ready,
    input  logic [NUM_CLIENTS-1:0]                     cli_req_opcode,
    input  logic [NUM_CLIENTS-1:0][MEM_LEN_BITS-1:0]   cli_req_len,
    input  logic [NUM_CLIENTS-1:0][MEM_ADDR_BITS-1:0]  cli_req_addr,
    input  logic [NUM_CLIENTS-1:0]                     cli_wr_valid,
    output logic [NUM_CLIENTS-1:0]                     cli_wr_ready,
    input  logic [NUM_CLIENTS-1:0][MEM_DATA_BITS-1:0]  cli_wr_bits,
    output logic [NUM_CLIENTS-1:0]                     cli_rd_valid,
    input  logic [NUM_CLIENTS-1:0]                     cli_rd_ready,
    output logic [MEM_DATA_BITS-1:0]                   cli_rd_bits,
    output logic                                       mem_req_valid,
    output logic                                       mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]                    mem_req_len,
    output logic [MEM_ADDR_BITS-1:0]                   mem_req_addr,
    output logic                                       mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0]                   mem_wr_bits,
    input  logic                                       mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0]                   mem_rd_bits,
    output logic                                       mem_rd_ready
);

    localparam int IW = idx_bits(NUM_CLIENTS);

    mem_state_e               state_reg,  state_next;
    logic [IW-1:0]            grant_reg,  grant_next;
    logic                     opcode_reg, opcode_next;
    logic [MEM_LEN_BITS-1:0]  len_reg,    len_next;
    logic [MEM_ADDR_BITS-1:0] addr_reg,   addr_next;
    logic [MEM_LEN_BITS-1:0]  cnt_reg,    cnt_next;

    logic [NUM_CLIENTS-1:0] arb_grant;
    logic [IW-1:0]          arb_idx;
    logic                   arb_valid;
    logic                   arb_en;
    logic                   wr_beat;
    logic                   rd_beat;

    // Arbitration is held off while reset is asserted so no request is accepted then.
    assign arb_en = (state_reg == IDLE) && !reset;

    rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
        .clock       (clock),
        .reset       (reset),
        .req         (cli_req_valid),
        .en          (arb_en),
        .accept      (arb_valid),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign cli_req_ready = arb_grant;
    assign cli_rd_bits   = mem_rd_bits;

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
        logic is_granted;
        assign is_granted       = (grant_reg == IW'(gi));
        assign cli_wr_ready[gi] = (state_reg == WDATA) && is_granted;
        assign cli_rd_valid[gi] = (state_reg == RDATA) && is_granted && mem_rd_valid;
    end

    assign mem_req_valid  = (state_reg == REQ);
    assign mem_req_opcode = opcode_reg;
    assign mem_req_len    = len_reg;
    assign mem_req_addr   = addr_reg;

    assign mem_wr_valid = (state_reg == WDATA) && cli_wr_valid[grant_reg];
    assign mem_wr_bits  = (state_reg == WDATA) ? cli_wr_bits[grant_reg] : '0;
    assign mem_rd_ready = (state_reg == RDATA) && cli_rd_ready[grant_reg];

    assign wr_beat = mem_wr_valid;
    assign rd_beat = mem_rd_valid && mem_rd_ready;

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        opcode_next = opcode_reg;
        len_next    = len_reg;
        addr_next   = addr_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (arb_valid) begin
                    grant_next  = arb_idx;
                    opcode_next = cli_req_opcode[arb_idx];
                    len_next    = cli_req_len[arb_idx];
                    addr_next   = cli_req_addr[arb_idx];
                    cnt_next    = cli_req_len[arb_idx];
                    state_next  = REQ;
                end
            end
            REQ: begin
                state_next = (opcode_reg == MEM_OP_WR) ? WDATA : RDATA;
            end
            WDATA, RDATA: begin
                // The counter holds beats remaining after this one; zero marks the last beat.
                if ((state_reg == WDATA) ? wr_beat : rd_beat) begin
                    if (cnt_reg == '0) state_next = IDLE;
                    else               cnt_next   = cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            opcode_reg <= 1'b0;
            len_reg    <= '0;
            addr_reg   <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            opcode_reg <= opcode_next;
            len_reg    <= len_next;
            addr_reg   <= addr_next;
            cnt_reg    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_vta_mem_arbiter.sv
// Directed bench for vta_mem_arbiter with four clients: read, write, contention,
// backpressure, maximum-length burst and reset in the middle of a burst.
module tb_vta_mem_arbiter;
    import vta_mem_pkg::*;

    localparam int NC = 4;
    localparam int LB = 8;
    localparam int AB = 64;
    localparam int DB = 64;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [NC-1:0]          cli_req_valid;
    logic [NC-1:0]          cli_req_ready;
    logic [NC-1:0]          cli_req_opcode;
    logic [NC-1:0][LB-1:0]  cli_req_len;
    logic [NC-1:0][AB-1:0]  cli_req_addr;
    logic [NC-1:0]          cli_wr_valid;
    logic [NC-1:0]          cli_wr_ready;
    logic [NC-1:0][DB-1:0]  cli_wr_bits;
    logic [NC-1:0]          cli_rd_valid;
    logic [NC-1:0]          cli_rd_ready;
    logic [DB-1:0]          cli_rd_bits;
    logic                   mem_req_valid;
    logic                   mem_req_opcode;
    logic [LB-1:0]          mem_req_len;
    logic [AB-1:0]          mem_req_addr;
    logic                   mem_wr_valid;
    logic [DB-1:0]          mem_wr_bits;
    logic                   mem_rd_valid;
    logic [DB-1:0]          mem_rd_bits;
    logic                   mem_rd_ready;

    int pass_cnt  = 0;
    int check_cnt = 0;

    vta_mem_arbiter #(
        .NUM_CLIENTS(NC), .MEM_LEN_BITS(LB), .MEM_ADDR_BITS(AB), .MEM_DATA_BITS(DB)
    ) dut (
        .clock(clock), .reset(reset),
        .cli_req_valid(cli_req_valid), .cli_req_ready(cli_req_ready),
        .cli_req_opcode(cli_req_opcode), .cli_req_len(cli_req_len),
        .cli_req_addr(cli_req_addr),
        .cli_wr_valid(cli_wr_valid), .cli_wr_ready(cli_wr_ready), .cli_wr_bits(cli_wr_bits),
        .cli_rd_valid(cli_rd_valid), .cli_rd_ready(cli_rd_ready), .cli_rd_bits(cli_rd_bits),
        .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
        .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
        .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
        .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %-18s got %0h", tag, got);
        end else begin
            $display("FAIL %-18s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        cli_req_valid  = '0;
        cli_req_opcode = '0;
        cli_req_len    = '0;
        cli_req_addr   = '0;
        cli_wr_valid   = '0;
        cli_wr_bits    = '0;
        cli_rd_ready   = '0;
        mem_rd_valid   = 1'b0;
        mem_rd_bits    = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Presents one request, checks its grant, then checks the memory request cycle.
    // Client fields are scrambled after the handshake; the latched copy must not follow.
    task automatic handshake(input int idx, input logic op, input int len, input logic [63:0] addr);
        logic [63:0] onehot;
        onehot = 64'd1 << idx;
        @(negedge clock);
        cli_req_valid[idx]  = 1'b1;
        cli_req_opcode[idx] = op;
        cli_req_len[idx]    = LB'(len);
        cli_req_addr[idx]   = addr;
        #1;
        check("req_ready", 64'(cli_req_ready), onehot);
        @(negedge clock);
        cli_req_valid[idx]  = 1'b0;
        cli_req_opcode[idx] = ~op;
        cli_req_len[idx]    = 8'h5A;
        cli_req_addr[idx]   = 64'hFFFF;
        #1;
        check("mem_req_valid", 64'(mem_req_valid), 64'd1);
        check("mem_req_opcode", 64'(mem_req_opcode), 64'(op));
        check("mem_req_len", 64'(mem_req_len), 64'(len));
        check("mem_req_addr", mem_req_addr, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int last;
        int beats;
        logic [9:0] bp_pat;

        clear_inputs();
        reset = 1'b1;
        cli_req_valid[1] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        #1;
        check("rst_req_ready", 64'(cli_req_ready), 64'd0);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_req_fields", {mem_req_len, 7'd0, mem_req_opcode}, 64'd0);
        check("rst_req_addr", mem_req_addr, 64'd0);
        check("rst_wr_valid", 64'(mem_wr_valid), 64'd0);
        check("rst_rd_ready", 64'(mem_rd_ready), 64'd0);
        check("rst_cli_rdwr", 64'({cli_wr_ready, cli_rd_valid}), 64'd0);
        cli_req_valid = '0;
        @(negedge clock);
        reset = 1'b0;

        // Single read: client0, 4 beats, only client0 sees valid.
        handshake(0, MEM_OP_RD, 3, 64'h1000);
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            mem_rd_valid    = 1'b1;
            mem_rd_bits     = 64'hA0 + 64'(b);
            cli_rd_ready[0] = 1'b1;
            #1;
            check("rd_valid", 64'(cli_rd_valid), 64'h1);
            check("rd_mem_ready", 64'(mem_rd_ready), 64'd1);
            check("rd_bits", cli_rd_bits, 64'hA0 + 64'(b));
        end
        @(negedge clock);
        #1;
        check("rd_end_ready", 64'(mem_rd_ready), 64'd0);
        check("rd_end_valid", 64'(cli_rd_valid), 64'd0);
        clear_inputs();

        // Single write: client1, one beat.
        handshake(1, MEM_OP_WR, 0, 64'h2000);
        @(negedge clock);
        cli_wr_valid[1] = 1'b1;
        cli_wr_bits[1]  = 64'hDEAD_BEEF;
        #1;
        check("wr_valid", 64'(mem_wr_valid), 64'd1);
        check("wr_bits", mem_wr_bits, 64'hDEAD_BEEF);
        check("wr_ready", 64'(cli_wr_ready), 64'h2);
        @(negedge clock);
        #1;
        check("wr_end_valid", 64'(mem_wr_valid), 64'd0);
        check("wr_end_ready", 64'(cli_wr_ready), 64'd0);
        clear_inputs();

        // Contention: four clients writing len 0 continuously, pointer starting at 0.
        pulse_reset();
        @(negedge clock);
        cli_req_valid  = '1;
        cli_req_opcode = '1;
        cli_wr_valid   = '1;
        hs   = 0;
        last = 0;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (cli_req_ready != '0) begin
                check("cont_grant", 64'(cli_req_ready), 64'd1 << (hs % 4));
                if (hs > 0) check("cont_gap", 64'(c - last), 64'd3);
                last = c;
                hs++;
            end
            @(negedge clock);
        end
        check("cont_count", 64'(hs), 64'd8);
        clear_inputs();

        // Backpressure: client2 read of 3 beats, rd_ready low for 5 cycles mid-burst.
        handshake(2, MEM_OP_RD, 2, 64'h3000);
        bp_pat = 10'b11_1100_0001;
        beats  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            mem_rd_valid    = 1'b1;
            mem_rd_bits     = 64'hB0 + 64'(beats);
            cli_rd_ready[2] = bp_pat[k];
            #1;
            if (beats < 3) begin
                check("bp_mem_rd_ready", 64'(mem_rd_ready), 64'(bp_pat[k]));
                check("bp_rd_valid", 64'(cli_rd_valid), 64'h4);
                if (cli_rd_valid[2] && cli_rd_ready[2]) begin
                    check("bp_data", cli_rd_bits, 64'hB0 + 64'(beats));
                    beats++;
                end
            end else begin
                check("bp_after_ready", 64'(mem_rd_ready), 64'd0);
            end
        end
        check("bp_beats", 64'(beats), 64'd3);
        clear_inputs();

        // Maximum length: 256 write beats with periodic client stalls.
        handshake(1, MEM_OP_WR, 255, 64'h4000);
        beats = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            cli_wr_valid[1] = (c % 7 != 6);
            cli_wr_bits[1]  = 64'(beats);
            #1;
            if (!cli_wr_ready[1]) break;
            if (mem_wr_valid) begin
                if (beats == 255) check("max_last_bits", mem_wr_bits, 64'd255);
                beats++;
            end
        end
        check("max_beats", 64'(beats), 64'd256);
        check("max_idle", 64'(cli_wr_ready), 64'd0);
        clear_inputs();

        // Reset during beat 2 of an 8-beat read, then a fresh client2 request.
        handshake(0, MEM_OP_RD, 7, 64'h5000);
        for (int b = 0; b < 2; b++) begin
            @(negedge clock);
            mem_rd_valid    = 1'b1;
            cli_rd_ready[0] = 1'b1;
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("mrst_rd_ready", 64'(mem_rd_ready), 64'd0);
        check("mrst_rd_valid", 64'(cli_rd_valid), 64'd0);
        check("mrst_req_valid", 64'(mem_req_valid), 64'd0);
        check("mrst_req_fields", {mem_req_len, 7'd0, mem_req_opcode}, 64'd0);
        check("mrst_req_addr", mem_req_addr, 64'd0);
        check("mrst_wr", 64'({cli_wr_ready, mem_wr_valid}), 64'd0);
        reset = 1'b0;
        clear_inputs();
        handshake(2, MEM_OP_RD, 1, 64'h6000);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
